// File: rtl/reg_file_sweep.sv
// Register file: two combinational read ports and one swap, move or write per cycle.
// A sequential clear sweep clears one register per cycle and reports busy/done.
module reg_file_sweep #(
  parameter int DW     = 8,
  parameter int PW     = 4,
  parameter bit BYPASS = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [DW-1:0] dat_in,
  input  logic [PW-1:0] rd_addrA,
  input  logic [PW-1:0] rd_addrB,
  input  logic          mv_en,
  input  logic [PW-1:0] mv_addr,
  input  logic          swp_en,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic          busy,
  output logic          done,
  output logic          wr_drop
);

  // state | meaning
  // IDLE  | normal operation, swap/move/write accepted
  // CLR   | sweep clearing core[ptr] each edge, all operations discarded
  typedef enum logic {IDLE, CLR} state_t;

  localparam int DEPTH = 2 ** PW;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wr_drop_q, wr_drop_d;
  logic [DW-1:0] core_q [DEPTH];
  logic [DW-1:0] core_d [DEPTH];
  logic          last_ptr;
  logic          bypass_a, bypass_b;

  assign last_ptr = (ptr_q == {PW{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) core_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_drop_q <= wr_drop_d;
      for (int i = 0; i < DEPTH; i++) core_q[i] <= core_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLR;
          ptr_d   = '0;
        end
      end
      CLR: begin
        if (start) begin
          ptr_d = '0;
        end else if (last_ptr) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy_d = (state_d == CLR);
    done_d = (state_q == CLR) && !start && last_ptr;
  end

  // A start seen mid-sweep restarts without clearing on that edge, same as from IDLE.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) core_d[i] = core_q[i];
    wr_drop_d = 1'b0;
    if (state_q == CLR) begin
      if (!start) core_d[ptr_q] = '0;
      wr_drop_d = wr_en | mv_en | swp_en;
    end else if (swp_en) begin
      core_d[rd_addrA] = core_q[rd_addrB];
      core_d[rd_addrB] = core_q[rd_addrA];
      wr_drop_d = mv_en | wr_en;
    end else if (mv_en) begin
      core_d[mv_addr] = core_q[rd_addrA];
      wr_drop_d = wr_en;
    end else if (wr_en) begin
      core_d[wr_addr] = dat_in;
    end
  end

  always_comb begin
    bypass_a = BYPASS && wr_en && !mv_en && !swp_en && !busy_q && (wr_addr == rd_addrA);
    bypass_b = BYPASS && wr_en && !mv_en && !swp_en && !busy_q && (wr_addr == rd_addrB);
    datA_out = bypass_a ? dat_in : core_q[rd_addrA];
    datB_out = bypass_b ? dat_in : core_q[rd_addrB];
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_reg_file_sweep.sv
// Directed bench for reg_file_sweep (DW=8, PW=4, BYPASS=1).
module tb_reg_file_sweep;

  logic       clk = 1'b0;
  logic       reset, start, wr_en, mv_en, swp_en;
  logic [3:0] wr_addr, rd_addrA, rd_addrB, mv_addr;
  logic [7:0] dat_in, datA_out, datB_out;
  logic       busy, done, wr_drop;

  int total = 0;
  int bad   = 0;

  reg_file_sweep #(.DW(8), .PW(4), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
    .dat_in(dat_in), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .mv_en(mv_en),
    .mv_addr(mv_addr), .swp_en(swp_en), .datA_out(datA_out), .datB_out(datB_out),
    .busy(busy), .done(done), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; start = 0; wr_en = 0; mv_en = 0; swp_en = 0;
    wr_addr = 0; dat_in = 0; rd_addrA = 0; rd_addrB = 0; mv_addr = 0;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1; wr_addr = a; dat_in = d;
    tick();
    wr_en = 0;
  endtask

  task automatic fill_nonzero();
    for (int i = 0; i < 16; i++) write_reg(4'(i), 8'h80 | 8'(i));
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addrA = 4'(i);
      #1;
      total++;
      if (datA_out !== 8'h00) begin
        bad++;
        $display("FAIL %s r%0d: got %h want 00", tag, i, datA_out);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) write_reg(4'(i), 8'hA5);
    rd_addrA = 4'd7; #1;
    total++;
    if (datA_out !== 8'hA5) begin bad++; $display("FAIL preload r7: got %h want a5", datA_out); end
    reset = 1; tick(); reset = 0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_drop !== 1'b0) begin
      bad++; $display("FAIL reset_status: busy=%b done=%b drop=%b want 0 0 0", busy, done, wr_drop);
    end
    check_all_zero("reset_clear");
  endtask

  task automatic test_write_read();
    write_reg(4'd5, 8'h3C);
    write_reg(4'd9, 8'h7E);
    rd_addrA = 4'd5; rd_addrB = 4'd9; #1;
    total++;
    if (datA_out !== 8'h3C || datB_out !== 8'h7E) begin
      bad++; $display("FAIL read_ab: got %h/%h want 3c/7e", datA_out, datB_out);
    end
    // bypass: same-cycle forwarding on a plain write
    rd_addrA = 4'd2; wr_en = 1; wr_addr = 4'd2; dat_in = 8'h11; #1;
    total++;
    if (datA_out !== 8'h11) begin bad++; $display("FAIL bypass: got %h want 11", datA_out); end
    mv_en = 1; mv_addr = 4'd2; rd_addrA = 4'd5; rd_addrB = 4'd2; #1;
    total++;
    if (datB_out !== 8'h00) begin bad++; $display("FAIL no_bypass_move: got %h want 00", datB_out); end
    mv_en = 0; rd_addrA = 4'd2; #1;
    tick(); wr_en = 0;
    total++;
    if (datA_out !== 8'h11) begin bad++; $display("FAIL write_r2: got %h want 11", datA_out); end
  endtask

  task automatic test_swap_move();
    write_reg(4'd1, 8'h10);
    write_reg(4'd2, 8'h20);
    write_reg(4'd3, 8'h33);
    swp_en = 1; rd_addrA = 4'd1; rd_addrB = 4'd2;
    wr_en = 1; wr_addr = 4'd3; dat_in = 8'h99;
    tick();
    swp_en = 0; wr_en = 0; #1;
    total++;
    if (wr_drop !== 1'b1) begin bad++; $display("FAIL swap_drop: got %b want 1", wr_drop); end
    total++;
    if (datA_out !== 8'h20 || datB_out !== 8'h10) begin
      bad++; $display("FAIL swap: got %h/%h want 20/10", datA_out, datB_out);
    end
    rd_addrA = 4'd3; #1;
    total++;
    if (datA_out !== 8'h33) begin bad++; $display("FAIL dropped_write: got %h want 33", datA_out); end
    mv_en = 1; rd_addrA = 4'd1; mv_addr = 4'd7;
    tick(); mv_en = 0;
    rd_addrB = 4'd7; #1;
    total++;
    if (datB_out !== 8'h20 || wr_drop !== 1'b0) begin
      bad++; $display("FAIL move: got %h drop=%b want 20 drop=0", datB_out, wr_drop);
    end
    swp_en = 1; rd_addrA = 4'd3; rd_addrB = 4'd3;
    tick(); swp_en = 0; #1;
    total++;
    if (datA_out !== 8'h33 || wr_drop !== 1'b0) begin
      bad++; $display("FAIL swap_same: got %h drop=%b want 33 drop=0", datA_out, wr_drop);
    end
    mv_en = 1; rd_addrA = 4'd3; mv_addr = 4'd3;
    tick(); mv_en = 0; #1;
    total++;
    if (datA_out !== 8'h33) begin bad++; $display("FAIL move_self: got %h want 33", datA_out); end
    mv_en = 1; rd_addrA = 4'd3; mv_addr = 4'd8; wr_en = 1; wr_addr = 4'd8; dat_in = 8'hEE;
    tick(); mv_en = 0; wr_en = 0;
    rd_addrB = 4'd8; #1;
    total++;
    if (datB_out !== 8'h33 || wr_drop !== 1'b1) begin
      bad++; $display("FAIL move_over_write: got %h drop=%b want 33 drop=1", datB_out, wr_drop);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_r4;
    fill_nonzero();
    rd_addrA = 4'd4;
    start = 1; tick(); start = 0;   // edge N
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL sweep_start: busy=%b done=%b want 1 0", busy, done);
    end
    for (int k = 1; k <= 16; k++) begin
      rd_addrA = 4'd4;
      if (k == 3) begin wr_en = 1; wr_addr = 4'd0; dat_in = 8'h55; end
      tick();
      wr_en = 0; #1;
      exp_r4 = (k < 5) ? 8'h84 : 8'h00;
      total++;
      if (datA_out !== exp_r4) begin bad++; $display("FAIL sweep_r4 k=%0d: got %h want %h", k, datA_out, exp_r4); end
      total++;
      if (busy !== (k < 16) || done !== (k == 16) || wr_drop !== (k == 3)) begin
        bad++;
        $display("FAIL sweep_status k=%0d: busy=%b done=%b drop=%b want %b %b %b",
                 k, busy, done, wr_drop, k < 16, k == 16, k == 3);
      end
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL sweep_done_pulse: done=%b busy=%b want 0 0", done, busy);
    end
    check_all_zero("sweep_clear");
  endtask

  task automatic test_restart();
    fill_nonzero();
    start = 1; tick(); start = 0;
    for (int k = 1; k <= 5; k++) tick();
    start = 1; tick(); start = 0;   // sweep edge 6 restarts
    rd_addrA = 4'd5; rd_addrB = 4'd4; #1;
    total++;
    if (datA_out !== 8'h85 || datB_out !== 8'h00 || busy !== 1'b1) begin
      bad++; $display("FAIL restart_state: r5=%h r4=%h busy=%b want 85 00 1", datA_out, datB_out, busy);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      total++;
      if (done !== (k == 16) || busy !== (k < 16)) begin
        bad++; $display("FAIL restart_done k=%0d: done=%b busy=%b want %b %b", k, done, busy, k == 16, k < 16);
      end
    end
    check_all_zero("restart_clear");
  endtask

  task automatic test_reset_mid_sweep();
    fill_nonzero();
    start = 1; tick(); start = 0;
    for (int k = 1; k <= 5; k++) tick();
    reset = 1; tick(); reset = 0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_drop !== 1'b0) begin
      bad++; $display("FAIL mid_reset_status: busy=%b done=%b drop=%b want 0 0 0", busy, done, wr_drop);
    end
    check_all_zero("mid_reset_clear");
    write_reg(4'd12, 8'h5A);
    rd_addrA = 4'd12; #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_drop !== 1'b0 || datA_out !== 8'h5A) begin
      bad++; $display("FAIL mid_reset_idle: busy=%b done=%b drop=%b r12=%h want 0 0 0 5a",
                      busy, done, wr_drop, datA_out);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1; tick(); tick(); reset = 0;
    test_reset();
    test_write_read();
    test_swap_move();
    test_sweep();
    test_restart();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sweep.md
Name: reg_file_sweep

Overview:
- Parametrised next-generation register file for the datapath core.
- Configurable data width and depth.
- Two combinational read ports, plus one write, move or swap operation per cycle.
- Full single-cycle clear on reset; multi-cycle sequential clear sweep on start, with busy/done status.
- Optional write-to-read bypass.

Parameters:
DW, 8, data width in bits
PW, 4, pointer width; depth = 2**PW registers
BYPASS, 0, 1 = read ports forward same-cycle dat_in on write-address match

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous active-high reset
start  input  1  begin clear sweep (one register per cycle)
wr_en  input  1  write enable
wr_addr  input  PW  write pointer
dat_in  input  DW  write data
rd_addrA  input  PW  read pointer A; also move/swap source
rd_addrB  input  PW  read pointer B; also swap partner
mv_en  input  1  move: core[mv_addr] <= core[rd_addrA]
mv_addr  input  PW  move destination
swp_en  input  1  swap core[rd_addrA] and core[rd_addrB]
datA_out  output  DW  read data A (combinational)
datB_out  output  DW  read data B (combinational)
busy  output  1  clear sweep in progress
done  output  1  one-cycle pulse, cycle after last register cleared
wr_drop  output  1  one-cycle pulse, cycle after a write/move/swap was discarded

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Reset (sampled high at posedge):
  - All 2**PW registers <= 0 in the same edge.
  - FSM returns to IDLE.
  - Outputs after reset: busy=0, done=0, wr_drop=0, datA_out=datB_out=0.
  - Reset overrides every other input, including mid-sweep.
- Reads:
  - datA_out = core[rd_addrA]; datB_out = core[rd_addrB]; zero latency.
  - If BYPASS=1, wr_en=1, mv_en=0, swp_en=0, busy=0 and wr_addr matches the read address: that port returns dat_in instead.
  - No bypass for move or swap.
- Operation priority each cycle (non-reset):
  - sweep, then swp_en, then mv_en, then wr_en.
  - Only the highest-priority operation executes.
  - A lower-priority write, move or swap that is discarded sets wr_drop=1 on the next cycle.
  - Sweep clear writes never count as dropped.
- Swap:
  - Single edge; both old values are read before update.
  - rd_addrA==rd_addrB: contents unchanged, no drop.
- Move: mv_addr==rd_addrA leaves contents unchanged.
- Write: core[wr_addr] <= dat_in.
- FSM states IDLE and CLR; ptr is a PW-bit counter.
  - IDLE & start: go to CLR, ptr<=0, busy<=1. No register is cleared on this edge.
  - CLR: core[ptr] <= 0 each edge, ptr increments.
  - CLR with ptr == 2**PW-1: clear it, go to IDLE, busy<=0, done<=1 for one cycle.
  - start while in CLR: restart, ptr<=0, state stays CLR, no done.
  - Sweep length: start at edge N → busy high from N+1 → last clear at edge N+2**PW → done high for the cycle after that edge.
  - ptr never wraps while in CLR.
- During CLR (busy=1):
  - wr_en, mv_en and swp_en are all discarded, each raising wr_drop next cycle.
  - Reads remain live: registers not yet swept return old contents, swept ones return 0.
- done, busy and wr_drop are registered outputs with no combinational path from inputs.

Test Plan:
- Reset with all registers preloaded 0xA5 (PW=4) → next cycle every rd_addr reads 0x00; busy=0, done=0.
- Write 0x3C to r5 then 0x7E to r9; read A=5, B=9 → datA_out=0x3C, datB_out=0x7E. With BYPASS=1, write 0x11 to r2 while rd_addrA=2 → datA_out=0x11 in the same cycle.
- r1=0x10, r2=0x20:
  - swp_en A=1, B=2 → r1=0x20, r2=0x10.
  - Same cycle wr_en to r3 → r3 unchanged, wr_drop=1 next cycle.
  - mv_en A=1, mv_addr=7 → r7=0x20.
- Fill r0..r15 with nonzero values, pulse start at edge N:
  - busy high from N+1.
  - r4 still nonzero until edge N+5.
  - done=1 for exactly one cycle after edge N+16, busy=0 at the same time.
  - All registers read 0.
  - wr_en at N+3 is dropped, with wr_drop=1 at N+4.
- Mid-sweep cases:
  - start again at sweep edge 6 → sweep restarts at r0, done only 16 edges later.
  - Separately, reset at sweep edge 6 → all registers 0, busy=0 and done=0 next cycle, FSM in IDLE.
